// File: rtl/motion_map_pkg.sv
// Shared constants and the packed-word record for the motion-map packer and its word FIFO.
package motion_map_pkg;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_FRAME_W    = 640;
    localparam int DEF_FRAME_H    = 480;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int FRAME_PIXELS   = DEF_FRAME_W * DEF_FRAME_H;

    typedef struct packed {
        logic [DEF_WORD_W-1:0] data;
        logic                  last;
    } map_word_t;

endpackage

// File: rtl/motion_map_packer_if.sv
// Packed-word valid/ready stream from the packer toward the motion-map writer.
interface motion_map_packer_if
    import motion_map_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic              word_last;

    modport master (output word_valid, output word_data, output word_last, input word_ready);
    modport slave  (input word_valid, input word_data, input word_last, output word_ready);

endinterface

// File: rtl/motion_map_fifo.sv
// Small synchronous word FIFO with a registered head; a push into a full FIFO
// succeeds only when the head is popped on the same edge.
module motion_map_fifo
    import motion_map_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter type T     = map_word_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     head,
    output logic empty,
    output logic full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem_r [DEPTH];
    T                 head_r;
    T                 head_next_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_after_pop_s;
    logic [CNT_W-1:0] count_next_s;
    logic             valid_r;
    logic             full_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Next pointers/occupancy and the word that becomes the head after this edge.
    always_comb begin
        full_s            = (count_r == CNT_W'(DEPTH));
        pop_ok_s          = pop && valid_r;
        push_ok_s         = push && (!full_s || pop_ok_s);
        rd_next_s         = rd_ptr_r + PTR_W'(pop_ok_s);
        count_after_pop_s = count_r - CNT_W'(pop_ok_s);
        count_next_s      = count_after_pop_s + CNT_W'(push_ok_s);
        head_next_s       = '0;
        // A word written into an otherwise empty FIFO bypasses storage to the head.
        if (count_after_pop_s != '0) begin
            head_next_s = mem_r[rd_next_s];
        end else if (push_ok_s) begin
            head_next_s = din;
        end else begin
            head_next_s = '0;
        end
    end

    // Storage, pointers and registered head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            head_r   <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            head_r   <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != '0);
            head_r   <= head_next_s;
        end
    end

    assign head  = head_r;
    assign empty = !valid_r;
    assign full  = full_s;

endmodule

// File: rtl/motion_map_packer.sv
// Packs per-pixel motion bits LSB-first into words, buffers them for the map
// writer and reports the motion-pixel count of each completed frame.
module motion_map_packer
    import motion_map_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int FRAME_W    = DEF_FRAME_W,
    parameter int FRAME_H    = DEF_FRAME_H,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FRAME_W * FRAME_H + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    motion_detected,
    input  logic                    sync_clr,
    motion_map_packer_if.master     word_bus,
    output logic [CNT_W-1:0]        motion_count,
    output logic                    count_valid,
    output logic                    overflow
);
    localparam int PIXELS = FRAME_W * FRAME_H;
    localparam int IDX_W  = $clog2(WORD_W);
    localparam int PIX_W  = $clog2(PIXELS);

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
    } word_t;

    logic [WORD_W-1:0] shift_r;
    logic [WORD_W-1:0] word_s;
    logic [IDX_W-1:0]  bit_idx_r;
    logic [PIX_W-1:0]  pix_cnt_r;
    logic [CNT_W-1:0]  run_cnt_r;
    logic [CNT_W-1:0]  run_sum_s;
    logic [CNT_W-1:0]  motion_count_r;
    logic              count_valid_r;
    logic              overflow_r;
    logic              accept_s;
    logic              frame_end_s;
    logic              word_done_s;
    logic              pop_s;
    logic              drop_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    word_t             push_word_s;
    word_t             head_s;

    // Pixel acceptance, word completion and the word image including the current bit.
    always_comb begin
        accept_s          = enable && !sync_clr;
        frame_end_s       = accept_s && (pix_cnt_r == PIX_W'(PIXELS - 1));
        word_done_s       = accept_s && ((bit_idx_r == IDX_W'(WORD_W - 1)) || frame_end_s);
        run_sum_s         = run_cnt_r + CNT_W'(motion_detected);
        word_s            = shift_r;
        word_s[bit_idx_r] = motion_detected;
        push_word_s.data  = word_s;
        push_word_s.last  = frame_end_s;
        pop_s             = word_bus.word_ready && !fifo_empty_s;
        drop_s            = word_done_s && fifo_full_s && !pop_s;
    end

    // Shift register, bit/pixel position and per-frame motion counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r        <= '0;
            bit_idx_r      <= '0;
            pix_cnt_r      <= '0;
            run_cnt_r      <= '0;
            motion_count_r <= '0;
            count_valid_r  <= 1'b0;
        end else if (sync_clr) begin
            shift_r       <= '0;
            bit_idx_r     <= '0;
            pix_cnt_r     <= '0;
            run_cnt_r     <= '0;
            count_valid_r <= 1'b0;
        end else if (accept_s) begin
            if (word_done_s) begin
                shift_r   <= '0;
                bit_idx_r <= '0;
            end else begin
                shift_r   <= word_s;
                bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
            end
            if (frame_end_s) begin
                pix_cnt_r      <= '0;
                run_cnt_r      <= '0;
                motion_count_r <= run_sum_s;
                count_valid_r  <= 1'b1;
            end else begin
                pix_cnt_r     <= pix_cnt_r + PIX_W'(1'b1);
                run_cnt_r     <= run_sum_s;
                count_valid_r <= 1'b0;
            end
        end else begin
            count_valid_r <= 1'b0;
        end
    end

    // Sticky drop flag; only a hard reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    motion_map_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (word_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (sync_clr),
        .push  (word_done_s),
        .din   (push_word_s),
        .pop   (pop_s),
        .head  (head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    assign word_bus.word_valid = !fifo_empty_s;
    assign word_bus.word_data  = head_s.data;
    assign word_bus.word_last  = head_s.last;
    assign motion_count        = motion_count_r;
    assign count_valid         = count_valid_r;
    assign overflow            = overflow_r;

endmodule

// File: tb/tb_motion_map_packer.sv
// Scoreboard bench for motion_map_packer: 8-bit words, 4x3 frames, 4-deep FIFO.
module tb_motion_map_packer;
    localparam int WORD_W     = 8;
    localparam int FRAME_W    = 4;
    localparam int FRAME_H    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FRAME_W * FRAME_H + 1);

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
    } exp_word_t;

    logic             clk             = 1'b0;
    logic             rst             = 1'b1;
    logic             enable          = 1'b0;
    logic             motion_detected = 1'b0;
    logic             sync_clr        = 1'b0;
    logic [CNT_W-1:0] motion_count;
    logic             count_valid;
    logic             overflow;

    int               total = 0;
    int               bad   = 0;
    exp_word_t        word_q [$];
    logic [CNT_W-1:0] count_q [$];
    exp_word_t        mon_w;
    logic [CNT_W-1:0] mon_c;

    motion_map_packer_if #(.WORD_W(WORD_W)) bus ();

    motion_map_packer #(
        .WORD_W     (WORD_W),
        .FRAME_W    (FRAME_W),
        .FRAME_H    (FRAME_H),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .motion_detected (motion_detected),
        .sync_clr        (sync_clr),
        .word_bus        (bus),
        .motion_count    (motion_count),
        .count_valid     (count_valid),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_word(input logic [WORD_W-1:0] d, input logic l);
        word_q.push_back({d, l});
    endtask

    task automatic exp_count(input logic [CNT_W-1:0] c);
        count_q.push_back(c);
    endtask

    task automatic send_pixel(input logic b);
        enable          = 1'b1;
        motion_detected = b;
        @(posedge clk);
        #1;
        enable          = 1'b0;
        motion_detected = 1'b0;
    endtask

    // Sends pixels first..last_i of a 12-bit frame image (bit i = pixel i).
    task automatic send_bits(input logic [11:0] bits, input int first, input int last_i, input bit gaps);
        for (int i = first; i <= last_i; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_pixel(bits[i]);
        end
    endtask

    // Monitor: compares every accepted word and every count pulse against the queues.
    always @(negedge clk) begin
        if (rst && bus.word_valid && bus.word_ready) begin
            if (word_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL word_extra: got data=%0h last=%0b, expected no word", bus.word_data, bus.word_last);
            end else begin
                mon_w = word_q.pop_front();
                chk("word_data", 32'(bus.word_data), 32'(mon_w.data));
                chk("word_last", 32'(bus.word_last), 32'(mon_w.last));
            end
        end
        if (rst && count_valid) begin
            if (count_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL count_extra: got count=%0d, expected no pulse", motion_count);
            end else begin
                mon_c = count_q.pop_front();
                chk("motion_count", 32'(motion_count), 32'(mon_c));
            end
        end
    end

    initial begin
        bus.word_ready = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_data", 32'(bus.word_data), 32'd0);
        chk("rst_last", 32'(bus.word_last), 32'd0);
        chk("rst_cv", 32'(count_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_count", 32'(motion_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Continuous frame 1,0,1,1,0,0,0,1,1,1,1,1.
        exp_word(8'h8D, 1'b0);
        exp_word(8'h0F, 1'b1);
        exp_count(4'd8);
        send_bits(12'hF8D, 0, 11, 1'b0);
        chk("cv_pulse", 32'(count_valid), 32'd1);
        chk("count_t1", 32'(motion_count), 32'd8);
        @(posedge clk);
        #1;
        chk("cv_one_cycle", 32'(count_valid), 32'd0);

        // Same frame with enable gaps.
        exp_word(8'h8D, 1'b0);
        exp_word(8'h0F, 1'b1);
        exp_count(4'd8);
        send_bits(12'hF8D, 0, 11, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Fill the FIFO, then push into it while the head is popped.
        bus.word_ready = 1'b0;
        exp_word(8'h8D, 1'b0);
        exp_word(8'h0F, 1'b1);
        exp_count(4'd8);
        exp_word(8'hFF, 1'b0);
        exp_word(8'h0F, 1'b1);
        exp_count(4'd12);
        exp_word(8'hAA, 1'b0);
        exp_word(8'h01, 1'b1);
        exp_count(4'd5);
        send_bits(12'hF8D, 0, 11, 1'b0);
        send_bits(12'hFFF, 0, 11, 1'b0);
        chk("full_valid", 32'(bus.word_valid), 32'd1);
        chk("ovf_before_push", 32'(overflow), 32'd0);
        send_bits(12'h1AA, 0, 6, 1'b0);
        bus.word_ready = 1'b1;
        send_bits(12'h1AA, 7, 11, 1'b0);
        chk("ovf_after_push", 32'(overflow), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("drained_full", 32'(bus.word_valid), 32'd0);

        // Three frames with ready low: last two words are dropped.
        bus.word_ready = 1'b0;
        exp_word(8'h8D, 1'b0);
        exp_word(8'h0F, 1'b1);
        exp_word(8'hFF, 1'b0);
        exp_word(8'h0F, 1'b1);
        exp_count(4'd8);
        exp_count(4'd12);
        exp_count(4'd0);
        send_bits(12'hF8D, 0, 11, 1'b0);
        send_bits(12'hFFF, 0, 11, 1'b0);
        send_bits(12'h000, 0, 11, 1'b0);
        chk("overflow_set", 32'(overflow), 32'd1);
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_valid", 32'(bus.word_valid), 32'd1);
        end
        @(negedge clk);
        chk("drain_empty", 32'(bus.word_valid), 32'd0);
        chk("overflow_sticky", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;

        // Frame abort after five all-ones pixels.
        bus.word_ready = 1'b0;
        exp_count(4'd8);
        send_bits(12'hF8D, 0, 11, 1'b0);
        send_bits(12'hFFF, 0, 4, 1'b0);
        chk("pre_clr_valid", 32'(bus.word_valid), 32'd1);
        sync_clr = 1'b1;
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        chk("clr_flush", 32'(bus.word_valid), 32'd0);
        chk("clr_count_hold", 32'(motion_count), 32'd8);
        chk("clr_no_pulse", 32'(count_valid), 32'd0);
        bus.word_ready = 1'b1;
        exp_word(8'h00, 1'b0);
        exp_word(8'h00, 1'b1);
        exp_count(4'd0);
        send_bits(12'h000, 0, 10, 1'b0);
        chk("count_held", 32'(motion_count), 32'd8);
        send_bits(12'h000, 11, 11, 1'b0);
        chk("count_zero", 32'(motion_count), 32'd0);
        chk("cv_after_clr", 32'(count_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset mid-word with two words queued.
        bus.word_ready = 1'b0;
        exp_count(4'd8);
        send_bits(12'hF8D, 0, 11, 1'b0);
        send_bits(12'hFFF, 0, 2, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.word_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.word_valid), 32'd0);
        chk("arst_data", 32'(bus.word_data), 32'd0);
        chk("arst_last", 32'(bus.word_last), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_count", 32'(motion_count), 32'd0);
        chk("arst_cv", 32'(count_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.word_ready = 1'b1;
        exp_word(8'h8D, 1'b0);
        exp_word(8'h0F, 1'b1);
        exp_count(4'd8);
        send_bits(12'hF8D, 0, 11, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        chk("words_left", 32'(word_q.size()), 32'd0);
        chk("counts_left", 32'(count_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motion_map_packer.md
# motion_map_packer

Consumer end of the motion detector interface: samples the per-pixel `motion_detected` bit whenever `enable` is high, packs the bits LSB-first into `WORD_W`-bit words and buffers them in a small FIFO. Words leave on a valid/ready stream toward the motion-map writer. The block also produces a per-frame count of motion pixels. It sits directly after `motion_detector` in the motion_map_generator pipeline.

## Interface
- `WORD_W`, 32, packed word width (power of two, ≥ 8)
- `FRAME_W`, 640, pixels per line
- `FRAME_H`, 480, lines per frame
- `FIFO_DEPTH`, 4, word buffer depth (power of two, ≥ 2)
- `CNT_W`, $clog2(FRAME_W*FRAME_H+1), motion count width
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-low
- `enable`  in  1  detector output valid; one pixel per cycle when high; no backpressure
- `motion_detected`  in  1  detector result for current pixel
- `sync_clr`  in  1  synchronous frame abort
- `word_valid`  out  1  FIFO head valid
- `word_ready`  in  1  downstream accepts head
- `word_data`  out  WORD_W  packed bits; bit i = i-th pixel of the word
- `word_last`  out  1  head word is the final word of a frame
- `motion_count`  out  CNT_W  motion pixels in the last completed frame
- `count_valid`  out  1  one-cycle pulse when `motion_count` updates
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full

## Operation
- Pixel accepted on any rising edge with `enable`=1 and `sync_clr`=0. The bit is written at `bit_idx` of the shift register, `bit_idx` increments, and `pix_cnt` increments.
- Word completes when `bit_idx`=WORD_W-1 or the pixel is the frame's last (`pix_cnt`=FRAME_W*FRAME_H-1). The completed word, including the current bit, is pushed that same edge. Unused high bits of a partial final word are 0. `word_last` is tagged 1 on the frame's last word only.
- After a push, `bit_idx` and the shift register clear. At frame end, `pix_cnt` also wraps to 0.
- The running count adds the bit each accepted pixel. At the frame's last pixel, `motion_count` is loaded with running count + bit, `count_valid` pulses for 1 cycle, and the running count clears.
- FIFO pop on `word_valid && word_ready`. Push when full is allowed only if a pop happens the same cycle. Otherwise the word is dropped, `overflow` sets, and counting continues unaffected.
- `sync_clr`:
  - Has priority over `enable`.
  - Discards the partial word, clears `bit_idx`, `pix_cnt` and the running count, and flushes the FIFO.
  - Does not change `motion_count` and does not pulse `count_valid`.
  - Does not clear `overflow`. Only reset clears it.
- Reset values:
  - `word_valid`, `word_last`, `count_valid` and `overflow` are 0.
  - `word_data` and `motion_count` are 0.
  - All internal counters are 0 and the FIFO is empty.
- Reset mid-frame discards all state, with no partial flush.

## Timing
- Latency: the bit that completes a word is accepted at edge N. `word_valid`=1 after edge N when the FIFO was empty. `word_data` and `word_last` are driven from the registered FIFO head.
- `count_valid` is high for the cycle after edge N of the last pixel, with `motion_count` already updated.
- `word_data` and `word_last` hold stable while `word_valid`=1 and `word_ready`=0.
- `word_valid` stays high across back-to-back pops while the FIFO is non-empty. Throughput is 1 word/cycle.
- Input rate is ≤ 1 pixel/cycle. Gaps (`enable`=0) are allowed anywhere, including mid-word.

## Structure
- Package `motion_map_pkg` holds:
  - default `WORD_W`, `FRAME_W`, `FRAME_H` and `FIFO_DEPTH` constants
  - the `frame_pixels` constant
  - typedef `map_word_t` (struct: `data[WORD_W]`, `last`)
- Sub-module `motion_map_fifo`: a synchronous FIFO of `map_word_t`. It has push/pop/full/empty, a registered head and simultaneous push+pop when full.
- Packer logic (shift register, `bit_idx`, `pix_cnt`, motion counter) lives in the top module.

## Test plan
Bench parameters: WORD_W=8, FRAME_W=4, FRAME_H=3 (12 pixels), FIFO_DEPTH=4, `word_ready`=1 unless stated.

- Continuous frame, bits 1,0,1,1,0,0,0,1 then 1,1,1,1:
  - words 0x8D (last=0) and 0x0F (last=1)
  - `count_valid` pulse with `motion_count`=8, one cycle after the 12th pixel
- Same frame with random `enable` gaps: identical words and count; no word emitted during gaps.
- `word_ready`=0 for 3 full frames (6 words pushed):
  - first 4 words retained, 2 dropped
  - `overflow`=1 and stays 1 after `word_ready` rises
  - 4 correct words drain back-to-back
- FIFO full with `word_ready`=1 in the push cycle: push succeeds, no overflow, order preserved.
- `sync_clr` after 5 pixels of all-ones:
  - FIFO empties
  - next 12 pixels (all 0) give words 0x00, 0x00(last) and `motion_count`=0 (not 5)
  - previous `motion_count` held until then
- Assert `rst` low mid-word with 2 words queued: all outputs 0 immediately (asynchronous); after release, a fresh frame packs from bit 0.
